data_mem_mmio: RTL and testbench
================================

DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, RAM depth in 32-bit words, power of two.
REQ-002 SHALL have parameter TXQ_DEPTH, default 4, UART TX queue depth, power of two, >=2.
REQ-003 SHALL have parameter LED_W, default 8, and DIGI_W, default 12, giving the LED and digit register widths.
REQ-004 SHALL have one clock; reset is asynchronous and active-low, with ports named clk and reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 Address  input  32  byte address.
REQ-008 Write_data  input  32  store data.
REQ-009 Byte_en  input  4  RAM byte lanes; bit n enables byte n.
REQ-010 MemRead, MemWrite  input  1 each  access strobes.
REQ-011 Mem_data  output  32  registered read data.
REQ-012 Mem_valid  output  1  one-cycle pulse marking Mem_data valid.
REQ-013 led  output  LED_W; digi  output  DIGI_W.
REQ-014 uart_tx_data  output  8; uart_tx_valid  output  1; uart_tx_ready  input  1; together a valid/ready TX stream.
REQ-015 uart_rx_data  input  8; uart_rx_valid  input  1; a one-cycle strobe per received byte.
REQ-016 irq  output  1  timer interrupt, level-sensitive.

Function
REQ-017 Address map: RAM at 0x0..RAM_WORDS*4-1, word index Address[log2(RAM_WORDS)+1:2]. TH 0x40000000, TL 0x40000004, TCON 0x40000008, LED 0x4000000C, DIGI 0x40000010, UART_TX 0x40000018, UART_RX 0x4000001C, UART_CON 0x40000020.
REQ-018 Address outside these ranges: writes SHALL be ignored; reads SHALL return 0.
REQ-019 Read latency SHALL be 1 cycle: MemRead sampled at edge N gives Mem_data and Mem_valid=1 after edge N. Mem_data SHALL hold its value while Mem_valid=0.
REQ-020 MemRead and MemWrite in the same cycle at the same address SHALL return the pre-write value.
REQ-021 RAM writes SHALL update only the lanes set in Byte_en; Byte_en=0 SHALL change nothing.
REQ-022 MMIO writes SHALL ignore Byte_en and use the low register-width bits of Write_data.
REQ-023 Reads of LED and DIGI SHALL return their values zero-extended.
REQ-024 A write to UART_TX SHALL push Write_data[7:0] into the TX queue. If the queue is full before the edge, the byte SHALL be dropped and tx_drop set, even if a pop occurs in the same cycle.
REQ-025 uart_tx_valid SHALL equal "queue not empty"; uart_tx_data SHALL be the queue head. A pop SHALL occur on an edge where valid and ready are both 1. FIFO order SHALL be preserved and the pointers SHALL wrap.
REQ-026 uart_rx_valid SHALL latch uart_rx_data and set rx_full. If rx_full is already set, it SHALL also set rx_overrun, and the new byte SHALL overwrite the old one.
REQ-027 A read of UART_RX SHALL return the latched byte and clear rx_full. If uart_rx_valid arrives in the same cycle, the new byte is latched and rx_full stays 1.
REQ-028 UART_CON read bits: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_overrun, [4] tx_drop.
REQ-029 UART_CON write: writing 1 to bit 3 or bit 4 SHALL clear that flag; all other bits SHALL be ignored.
REQ-030 TCON bits: [0] enable, [1] irq_en, [2] status. Writing 1 to bit 2 SHALL clear status.
REQ-031 While enable=1, TL SHALL increment each cycle. When TL=0xFFFFFFFF, the next edge SHALL load TL<=TH and set status.
REQ-032 If a CPU write to TL coincides with a timer update, the CPU write SHALL win.
REQ-033 If a status set coincides with a W1C write, the set SHALL win.
REQ-034 irq SHALL equal status AND irq_en, with no added delay.

Reset
REQ-035 reset low SHALL asynchronously clear Mem_data, Mem_valid, led, digi, TH, TL, TCON, all UART flags and the TX queue pointers. Result: uart_tx_valid=0, irq=0.
REQ-036 RAM contents SHALL NOT be reset; their value after power-up is undefined.
REQ-037 Reset asserted mid-transfer SHALL discard all queued TX bytes and any pending read.

Structure
REQ-038 Package data_mem_mmio_pkg SHALL hold the address constants, the UART_CON and TCON bit indices, and the default parameter values.
REQ-039 The TX queue SHALL be a sub-module sync_fifo, parametrised by width and depth, exposing full and empty.

Verification
REQ-040 Write 0x11223344 to RAM 0x8 with Byte_en=4'b0101, then read 0x8 -> Mem_data=0x00220044 one cycle after MemRead, Mem_valid pulses once.
REQ-041 Hold uart_tx_ready=0 and push 5 bytes 0xA0..0xA4 (TXQ_DEPTH=4) -> UART_CON=0x11; then hold ready=1 -> bytes A0,A1,A2,A3 in order and tx_empty=1.
REQ-042 Two uart_rx_valid strobes of 0x55 then 0x66 with no read -> UART_RX reads 0x66, rx_overrun=1; write UART_CON 0x08 -> bit3 clears.
REQ-043 TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=0x3 -> irq asserts 2 cycles later and TL=0xFFFFFFFD; write TCON 0x7 -> irq drops the next cycle.
REQ-044 Assert reset mid-stream with 3 bytes queued and led=0xFF -> uart_tx_valid=0, led=0, irq=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for the data memory / MMIO block: address map, register
// bit positions, default sizes and the address decoder.
package data_mem_mmio_pkg;

  localparam int DEF_RAM_WORDS = 256;
  localparam int DEF_TXQ_DEPTH = 4;
  localparam int DEF_LED_W     = 8;
  localparam int DEF_DIGI_W    = 12;

  localparam logic [31:0] ADDR_TH       = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL       = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON     = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED      = 32'h4000_000C;
  localparam logic [31:0] ADDR_DIGI     = 32'h4000_0010;
  localparam logic [31:0] ADDR_UART_TX  = 32'h4000_0018;
  localparam logic [31:0] ADDR_UART_RX  = 32'h4000_001C;
  localparam logic [31:0] ADDR_UART_CON = 32'h4000_0020;

  localparam int CON_TX_FULL    = 0;
  localparam int CON_TX_EMPTY   = 1;
  localparam int CON_RX_FULL    = 2;
  localparam int CON_RX_OVERRUN = 3;
  localparam int CON_TX_DROP    = 4;

  localparam int TCON_ENABLE = 0;
  localparam int TCON_IRQ_EN = 1;
  localparam int TCON_STATUS = 2;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_DIGI,
    SEL_UART_TX,
    SEL_UART_RX,
    SEL_UART_CON
  } sel_e;

  // MMIO registers match on the full 32-bit address; anything else is unmapped.
  function automatic sel_e decode_addr(input logic [31:0] addr, input logic [31:0] ram_bytes);
    sel_e sel;
    sel = SEL_NONE;
    if (addr < ram_bytes) begin
      sel = SEL_RAM;
    end else begin
      case (addr)
        ADDR_TH:       sel = SEL_TH;
        ADDR_TL:       sel = SEL_TL;
        ADDR_TCON:     sel = SEL_TCON;
        ADDR_LED:      sel = SEL_LED;
        ADDR_DIGI:     sel = SEL_DIGI;
        ADDR_UART_TX:  sel = SEL_UART_TX;
        ADDR_UART_RX:  sel = SEL_UART_RX;
        ADDR_UART_CON: sel = SEL_UART_CON;
        default:       sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/data_mem_mmio_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is visible combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr_reg;
  logic [PW:0]      rd_ptr_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[PW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  assign head  = mem[rd_ptr_reg[PW-1:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]) && (wr_ptr_reg[PW] != rd_ptr_reg[PW]);

endmodule

// File: rtl/data_mem_mmio.sv
// Byte-lane data RAM plus memory-mapped timer, LED/digit registers and a
// UART TX queue / RX holding register, all behind one load/store port.
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int RAM_WORDS = DEF_RAM_WORDS,
  parameter int TXQ_DEPTH = DEF_TXQ_DEPTH,
  parameter int LED_W     = DEF_LED_W,
  parameter int DIGI_W    = DEF_DIGI_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Address,
  input  logic [31:0]       Write_data,
  input  logic [3:0]        Byte_en,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [31:0]       Mem_data,
  output logic              Mem_valid,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              irq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

  sel_e          sel;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_word;
  logic [31:0]   rd_word;
  logic          ram_we;

  assign sel     = decode_addr(Address, RAM_BYTES);
  assign ram_idx = Address[AW+1:2];
  assign ram_we  = MemWrite && (sel == SEL_RAM);

  // One byte-wide array per lane so each lane's write enable maps onto a RAM byte write.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [RAM_WORDS];
    always_ff @(posedge clk) begin
      if (ram_we && Byte_en[gi]) begin
        lane_mem[ram_idx] <= Write_data[8*gi +: 8];
      end
    end
    assign ram_word[8*gi +: 8] = lane_mem[ram_idx];
  end

  logic [31:0]       th_reg;
  logic [31:0]       tl_reg;
  logic              tcon_en_reg;
  logic              irq_en_reg;
  logic              status_reg;
  logic [LED_W-1:0]  led_reg;
  logic [DIGI_W-1:0] digi_reg;
  logic              tl_wrap;

  logic wr_th, wr_tl, wr_tcon, wr_led, wr_digi, wr_tx, wr_con, rd_rx;
  assign wr_th   = MemWrite && (sel == SEL_TH);
  assign wr_tl   = MemWrite && (sel == SEL_TL);
  assign wr_tcon = MemWrite && (sel == SEL_TCON);
  assign wr_led  = MemWrite && (sel == SEL_LED);
  assign wr_digi = MemWrite && (sel == SEL_DIGI);
  assign wr_tx   = MemWrite && (sel == SEL_UART_TX);
  assign wr_con  = MemWrite && (sel == SEL_UART_CON);
  assign rd_rx   = MemRead && (sel == SEL_UART_RX);

  assign tl_wrap = tcon_en_reg && (tl_reg == 32'hFFFF_FFFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_reg      <= '0;
      tl_reg      <= '0;
      tcon_en_reg <= 1'b0;
      irq_en_reg  <= 1'b0;
      status_reg  <= 1'b0;
      led_reg     <= '0;
      digi_reg    <= '0;
    end else begin
      if (wr_th)   th_reg   <= Write_data;
      if (wr_led)  led_reg  <= Write_data[LED_W-1:0];
      if (wr_digi) digi_reg <= Write_data[DIGI_W-1:0];
      if (wr_tl) begin
        tl_reg <= Write_data;
      end else if (tcon_en_reg) begin
        tl_reg <= tl_wrap ? th_reg : tl_reg + 32'd1;
      end
      if (wr_tcon) begin
        tcon_en_reg <= Write_data[TCON_ENABLE];
        irq_en_reg  <= Write_data[TCON_IRQ_EN];
      end
      // A wrap on the same edge as a write-one-to-clear keeps status set.
      if (tl_wrap) begin
        status_reg <= 1'b1;
      end else if (wr_tcon && Write_data[TCON_STATUS]) begin
        status_reg <= 1'b0;
      end
    end
  end

  assign irq  = status_reg && irq_en_reg;
  assign led  = led_reg;
  assign digi = digi_reg;

  logic tx_full, tx_empty, tx_push, tx_pop;
  assign tx_push = wr_tx && !tx_full;
  assign tx_pop  = !tx_empty && uart_tx_ready;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(TXQ_DEPTH)
  ) u_txq (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (Write_data[7:0]),
    .pop       (tx_pop),
    .head      (uart_tx_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  assign uart_tx_valid = !tx_empty;

  logic [7:0] rx_data_reg;
  logic       rx_full_reg;
  logic       rx_overrun_reg;
  logic       tx_drop_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_reg    <= '0;
      rx_full_reg    <= 1'b0;
      rx_overrun_reg <= 1'b0;
      tx_drop_reg    <= 1'b0;
    end else begin
      if (wr_tx && tx_full) begin
        tx_drop_reg <= 1'b1;
      end else if (wr_con && Write_data[CON_TX_DROP]) begin
        tx_drop_reg <= 1'b0;
      end
      if (wr_con && Write_data[CON_RX_OVERRUN]) rx_overrun_reg <= 1'b0;
      if (rd_rx) rx_full_reg <= 1'b0;
      // A new byte overrides both the read-clear and the overrun clear above.
      if (uart_rx_valid) begin
        rx_data_reg <= uart_rx_data;
        rx_full_reg <= 1'b1;
        if (rx_full_reg) rx_overrun_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (sel)
      SEL_RAM:  rd_word = ram_word;
      SEL_TH:   rd_word = th_reg;
      SEL_TL:   rd_word = tl_reg;
      SEL_TCON: begin
        rd_word[TCON_ENABLE] = tcon_en_reg;
        rd_word[TCON_IRQ_EN] = irq_en_reg;
        rd_word[TCON_STATUS] = status_reg;
      end
      SEL_LED:     rd_word[LED_W-1:0]  = led_reg;
      SEL_DIGI:    rd_word[DIGI_W-1:0] = digi_reg;
      SEL_UART_RX: rd_word[7:0]        = rx_data_reg;
      SEL_UART_CON: begin
        rd_word[CON_TX_FULL]    = tx_full;
        rd_word[CON_TX_EMPTY]   = tx_empty;
        rd_word[CON_RX_FULL]    = rx_full_reg;
        rd_word[CON_RX_OVERRUN] = rx_overrun_reg;
        rd_word[CON_TX_DROP]    = tx_drop_reg;
      end
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Mem_data  <= '0;
      Mem_valid <= 1'b0;
    end else begin
      Mem_valid <= MemRead;
      if (MemRead) Mem_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Randomized scoreboard bench for data_mem_mmio against a queue/array model.
module tb_data_mem_mmio;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_DIGI = 32'h4000_0010;
  localparam logic [31:0] A_TX   = 32'h4000_0018;
  localparam logic [31:0] A_RX   = 32'h4000_001C;
  localparam logic [31:0] A_CON  = 32'h4000_0020;
  localparam int          QDEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, Write_data, Mem_data;
  logic [3:0]  Byte_en;
  logic        MemRead, MemWrite, Mem_valid;
  logic [7:0]  led;
  logic [11:0] digi;
  logic [7:0]  uart_tx_data, uart_rx_data;
  logic        uart_tx_valid, uart_tx_ready, uart_rx_valid, irq;

  data_mem_mmio #(.RAM_WORDS(256), .TXQ_DEPTH(QDEPTH), .LED_W(8), .DIGI_W(12)) dut (
    .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data), .Byte_en(Byte_en),
    .MemRead(MemRead), .MemWrite(MemWrite), .Mem_data(Mem_data), .Mem_valid(Mem_valid),
    .led(led), .digi(digi), .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_ram [256];
  logic [31:0] m_th, m_tl;
  bit          m_en, m_ien, m_st;
  logic [7:0]  m_led;
  logic [11:0] m_digi;
  int          m_txcnt;
  bit          m_drop, m_ovr, m_rxfull;
  logic [7:0]  m_rx;

  // Scoreboard
  logic [31:0] rd_q [$];
  logic [7:0]  tx_exp_q [$];
  logic [31:0] last_data;
  logic [31:0] mon_exp;
  logic [7:0]  mon_tx;
  bit          mon_en = 1'b0;
  bit          use_const = 1'b0;
  logic [31:0] const_val;

  logic [31:0] wr_regs [7] = '{A_TH, A_TL, A_TCON, A_LED, A_DIGI, A_CON, A_TX};
  logic [31:0] rd_regs [8] = '{A_TH, A_TL, A_TCON, A_LED, A_DIGI, A_RX, A_CON, A_TX};
  logic [31:0] bad_addrs [6] = '{32'h0000_0400, 32'h4000_0014, 32'h4000_0024,
                                 32'h3FFF_FFFC, 32'h8000_0000, 32'h4000_0001};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a < 32'h400) return m_ram[a[9:2]];
    case (a)
      A_TH:    return m_th;
      A_TL:    return m_tl;
      A_TCON:  return {29'd0, m_st, m_ien, m_en};
      A_LED:   return {24'd0, m_led};
      A_DIGI:  return {20'd0, m_digi};
      A_RX:    return {24'd0, m_rx};
      A_CON:   return {27'd0, m_drop, m_ovr, m_rxfull, 1'(m_txcnt == 0), 1'(m_txcnt == QDEPTH)};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_th = '0; m_tl = '0; m_en = 0; m_ien = 0; m_st = 0;
    m_led = '0; m_digi = '0; m_txcnt = 0;
    m_drop = 0; m_ovr = 0; m_rxfull = 0; m_rx = '0;
    rd_q.delete(); tx_exp_q.delete();
    last_data = '0; use_const = 0;
  endtask

  // Applies the effect of one clock edge given the inputs currently driven.
  task automatic model_update();
    logic [31:0] a, wd, new_tl;
    bit wr, rdn, ov, was_full;
    int pre_cnt;
    a = Address; wd = Write_data; wr = MemWrite; rdn = MemRead;
    was_full = m_rxfull;
    pre_cnt = m_txcnt;
    if (rdn) begin
      rd_q.push_back(use_const ? const_val : m_read(a));
      use_const = 0;
    end
    if (wr && a < 32'h400)
      for (int b = 0; b < 4; b++)
        if (Byte_en[b]) m_ram[a[9:2]][8*b +: 8] = wd[8*b +: 8];
    if (wr && a == A_LED)  m_led = wd[7:0];
    if (wr && a == A_DIGI) m_digi = wd[11:0];
    if (wr && a == A_CON) begin
      if (wd[3]) m_ovr = 0;
      if (wd[4]) m_drop = 0;
    end
    if (pre_cnt > 0 && uart_tx_ready) m_txcnt--;
    if (wr && a == A_TX) begin
      if (pre_cnt == QDEPTH) m_drop = 1;
      else begin
        m_txcnt++;
        tx_exp_q.push_back(wd[7:0]);
      end
    end
    if (rdn && a == A_RX) m_rxfull = 0;
    if (uart_rx_valid) begin
      if (was_full) m_ovr = 1;
      m_rx = uart_rx_data;
      m_rxfull = 1;
    end
    ov = m_en && (m_tl == 32'hFFFF_FFFF);
    new_tl = m_tl;
    if (m_en) new_tl = ov ? m_th : m_tl + 32'd1;
    if (wr && a == A_TL) new_tl = wd;
    if (wr && a == A_TCON && wd[2]) m_st = 0;
    if (ov) m_st = 1;
    if (wr && a == A_TCON) begin m_en = wd[0]; m_ien = wd[1]; end
    if (wr && a == A_TH) m_th = wd;
    m_tl = new_tl;
  endtask

  task automatic idle_inputs();
    MemRead = 0; MemWrite = 0; Address = '0; Write_data = '0; Byte_en = '0; uart_rx_valid = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    idle_inputs();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    Address = a; Write_data = d; Byte_en = be; MemWrite = 1;
    step();
  endtask

  task automatic rd(input logic [31:0] a);
    Address = a; MemRead = 1;
    step();
  endtask

  task automatic rd_exp(input logic [31:0] a, input logic [31:0] e);
    use_const = 1; const_val = e;
    rd(a);
  endtask

  // Monitor: pops expectations whenever the DUT presents a response.
  always @(negedge clk) begin
    if (mon_en) begin
      if (Mem_valid) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_extra Mem_valid=1 with no read outstanding, Mem_data=%h", Mem_data);
        end else begin
          mon_exp = rd_q.pop_front();
          chk("rd_data", Mem_data, mon_exp);
          last_data = mon_exp;
          $display("read  data=%h expected=%h", Mem_data, mon_exp);
        end
      end else begin
        if (rd_q.size() != 0) begin
          checks++; errors++;
          $display("FAIL rd_latency Mem_valid=0 required 1");
          rd_q.delete(0);
        end
        chk("rd_hold", Mem_data, last_data);
      end
      chk("tx_valid", 32'(uart_tx_valid), 32'(m_txcnt != 0));
      if (uart_tx_valid && uart_tx_ready) begin
        if (tx_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_extra byte=%h with nothing queued", uart_tx_data);
        end else begin
          mon_tx = tx_exp_q.pop_front();
          chk("tx_data", 32'(uart_tx_data), 32'(mon_tx));
          $display("tx    byte=%h expected=%h", uart_tx_data, mon_tx);
        end
      end
      chk("irq", 32'(irq), 32'(m_st && m_ien));
      chk("led", 32'(led), 32'(m_led));
      chk("digi", 32'(digi), 32'(m_digi));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 0; uart_tx_ready = 0; uart_rx_data = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1;
    mon_en = 1;

    rd_exp(A_CON, 32'h02);
    rd_exp(A_TCON, 32'h0);
    for (int w = 0; w < 256; w++) wr(32'(w) << 2, $urandom, 4'hF);

    // Byte lanes
    wr(32'h8, 32'h0, 4'hF);
    wr(32'h8, 32'h1122_3344, 4'b0101);
    rd_exp(32'h8, 32'h0022_0044);
    wr(32'h8, 32'hFFFF_FFFF, 4'b0000);
    rd_exp(32'h8, 32'h0022_0044);

    // Read and write the same word in one cycle
    wr(32'h10, 32'hAAAA_5555, 4'hF);
    Address = 32'h10; Write_data = 32'h1234_5678; Byte_en = 4'hF; MemWrite = 1;
    use_const = 1; const_val = 32'hAAAA_5555; MemRead = 1;
    step();
    rd_exp(32'h10, 32'h1234_5678);

    // TX queue overflow and drain
    uart_tx_ready = 0;
    for (int i = 0; i < 5; i++) wr(A_TX, 32'hA0 + 32'(i), 4'h0);
    rd_exp(A_CON, 32'h11);
    uart_tx_ready = 1;
    repeat (5) step();
    rd_exp(A_CON, 32'h12);
    wr(A_CON, 32'h10, 4'h0);
    rd_exp(A_CON, 32'h02);

    // RX overrun
    uart_rx_data = 8'h55; uart_rx_valid = 1; step();
    step();
    uart_rx_data = 8'h66; uart_rx_valid = 1; step();
    rd_exp(A_RX, 32'h66);
    rd_exp(A_CON, 32'h0A);
    wr(A_CON, 32'h08, 4'h0);
    rd_exp(A_CON, 32'h02);

    // Timer wrap and interrupt
    wr(A_TH, 32'hFFFF_FFFD, 4'hF);
    wr(A_TL, 32'hFFFF_FFFE, 4'hF);
    wr(A_TCON, 32'h3, 4'hF);
    step();
    chk("irq_early", 32'(irq), 32'h0);
    step();
    chk("irq_after_wrap", 32'(irq), 32'h1);
    rd_exp(A_TL, 32'hFFFF_FFFD);
    wr(A_TCON, 32'h7, 4'hF);
    chk("irq_cleared", 32'(irq), 32'h0);
    wr(A_TCON, 32'h0, 4'hF);

    // Unmapped addresses
    wr(32'h4000_0014, 32'hFFFF_FFFF, 4'hF);
    wr(32'h0000_0400, 32'hDEAD_BEEF, 4'hF);
    rd_exp(32'h4000_0014, 32'h0);
    rd_exp(32'h0000_0400, 32'h0);
    rd_exp(32'h4000_0024, 32'h0);
    rd(32'h0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      uart_tx_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) begin
        uart_rx_valid = 1; uart_rx_data = 8'($urandom);
      end
      case ($urandom_range(0, 11))
        0, 1: begin
          Address = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
          Write_data = $urandom; Byte_en = 4'($urandom); MemWrite = 1;
        end
        2, 3: begin
          Address = {22'd0, 8'($urandom_range(0, 255)), 2'b00}; MemRead = 1;
        end
        4: begin
          Address = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          Write_data = $urandom; Byte_en = 4'($urandom); MemWrite = 1; MemRead = 1;
        end
        5: begin
          Address = wr_regs[$urandom_range(0, 6)]; MemWrite = 1; Byte_en = 4'($urandom);
          Write_data = $urandom;
          if (Address == A_TL || (Address == A_TH && $urandom_range(0, 1) == 1))
            Write_data = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
          if (Address == A_TCON) Write_data = 32'($urandom_range(0, 7));
        end
        6, 7: begin
          Address = rd_regs[$urandom_range(0, 7)]; MemRead = 1;
        end
        8: begin
          Address = bad_addrs[$urandom_range(0, 5)]; Write_data = $urandom; Byte_en = 4'hF;
          if ($urandom_range(0, 1) == 1) MemWrite = 1; else MemRead = 1;
        end
        9: begin
          Address = A_TX; Write_data = $urandom; MemWrite = 1;
        end
        default: ;
      endcase
      step();
    end

    uart_tx_ready = 1;
    repeat (QDEPTH + 2) step();
    chk("tx_drained", 32'(tx_exp_q.size()), 32'h0);

    // Reset in the middle of traffic
    uart_tx_ready = 0;
    wr(A_TCON, 32'h4, 4'hF);
    for (int i = 0; i < 3; i++) wr(A_TX, 32'hB0 + 32'(i), 4'h0);
    wr(A_LED, 32'hFF, 4'hF);
    wr(A_TH, 32'h0, 4'hF);
    wr(A_TL, 32'hFFFF_FFFF, 4'hF);
    wr(A_TCON, 32'h3, 4'hF);
    step();
    chk("pre_reset_irq", 32'(irq), 32'h1);
    chk("pre_reset_txv", 32'(uart_tx_valid), 32'h1);
    chk("pre_reset_led", 32'(led), 32'hFF);
    mon_en = 0;
    rd(32'h0);
    #1 reset = 0;
    #1;
    chk("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_mem_valid", 32'(Mem_valid), 32'h0);
    chk("rst_mem_data", Mem_data, 32'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1;
    mon_en = 1;
    rd_exp(A_CON, 32'h02);
    rd_exp(A_TCON, 32'h0);
    rd_exp(A_TL, 32'h0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
